packet_source: RTL

PACKET_SOURCE -- requirements
Module: packet_source

---
 rtl/packet_source.sv | 114 +++++++++++
 1 files changed

// File: rtl/packet_source.sv
// rtl/packet_source.sv - NoC packet generator with fixed or round-robin destination
// Emits src/dst/id/data packets under valid/ready handshake, optional per-packet gap and packet limit.
module packet_source #(
  parameter int WIDTH        = 32,
  parameter int N            = 16,
  parameter int N_ADDR_WIDTH = $clog2(N),
  parameter int NODE         = 0,
  parameter int DST_MODE     = 0,
  parameter int DEST         = 15,
  parameter int NUM_PKTS     = 0,
  parameter int GAP          = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [15:0]      sent_count,
  output logic             done
);

  localparam int DW = WIDTH - 2*N_ADDR_WIDTH - 8;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [N_ADDR_WIDTH-1:0] SRC      = N_ADDR_WIDTH'(NODE);
  localparam logic [N_ADDR_WIDTH-1:0] DST_INIT = (DST_MODE == 1) ? N_ADDR_WIDTH'((NODE + 1) % N)
                                                                 : N_ADDR_WIDTH'(DEST);

  // Next destination in round-robin order, never addressing our own node.
  function automatic logic [N_ADDR_WIDTH-1:0] dst_step(input logic [N_ADDR_WIDTH-1:0] d);
    int n;
    n = (int'(d) + 1) % N;
    if (n == NODE) n = (n + 1) % N;
    return N_ADDR_WIDTH'(n);
  endfunction

  logic [1:0]              state, state_nx;
  logic [GW-1:0]           gap_cnt, gap_nx;
  logic [7:0]              id, id_nx;
  logic [DW-1:0]           cnt, cnt_nx;
  logic [N_ADDR_WIDTH-1:0] dst, dst_nx;
  logic [15:0]             sent_nx;
  logic                    fire;

  always_comb begin
    fire     = valid_out & ready_in;
    state_nx = state;
    gap_nx   = gap_cnt;
    id_nx    = id;
    cnt_nx   = cnt;
    dst_nx   = dst;
    sent_nx  = sent_count;

    if (fire) begin
      id_nx  = id + 8'd1;
      cnt_nx = cnt + DW'(1);
      if (DST_MODE == 1) dst_nx = dst_step(dst);
      if (sent_count != 16'hFFFF) sent_nx = sent_count + 16'd1;
    end

    case (state)
      ST_IDLE: if (enable) state_nx = ST_SEND;
      ST_SEND: begin
        if (fire) begin
          if (NUM_PKTS != 0 && int'(sent_count) + 1 == NUM_PKTS) begin
            state_nx = ST_DONE;
          end else if (GAP > 0) begin
            state_nx = ST_GAP;
            gap_nx   = GW'(GAP - 1);
          end else if (!enable) begin
            state_nx = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) state_nx = enable ? ST_SEND : ST_IDLE;
        else               gap_nx   = gap_cnt - GW'(1);
      end
      default: state_nx = ST_DONE;
    endcase
  end

  // data_out is loaded from the post-transfer fields so it only changes on a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      gap_cnt    <= '0;
      id         <= 8'd0;
      cnt        <= '0;
      dst        <= DST_INIT;
      sent_count <= 16'd0;
      valid_out  <= 1'b0;
      done       <= 1'b0;
      data_out   <= '0;
    end else begin
      state      <= state_nx;
      gap_cnt    <= gap_nx;
      id         <= id_nx;
      cnt        <= cnt_nx;
      dst        <= dst_nx;
      sent_count <= sent_nx;
      valid_out  <= (state_nx == ST_SEND);
      done       <= (state_nx == ST_DONE);
      data_out   <= {SRC, dst_nx, id_nx, cnt_nx};
    end
  end

endmodule
